// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM: Moore datapath controls per state, 3-5 cycles per instruction.
// No backpressure; write enables and pulses are gated off while reset is high.
module multicycle_control_unit #(
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [2:0]         alu_control,
    output logic               reg_write,
    output logic               illegal_instr,
    output logic               instr_retire,
    output logic [STATE_W-1:0] state
);
    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    pc_update, branch, take;
    logic    ir_write_c, mem_write_c, reg_write_c, illegal_c, retire_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = FETCH;
        adr_src     = 1'b0;
        ir_write_c  = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_op      = ALU_ADD;
        pc_update   = 1'b0;
        branch      = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        retire_c    = 1'b0;
        case (state_q)
            FETCH: begin
                state_d    = DECODE;
                ir_write_c = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                // ALU precomputes OldPC + imm so a branch target sits in ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default: begin
                        state_d   = FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_FUNCT;
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALU_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                retire_c  = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            ALU_SUB: alu_control = 3'b001;
            ALU_FUNCT: begin
                case (funct3)
                    // only R-type (opcode[5]=1) can subtract; addi always adds
                    3'b000:  alu_control = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b100:  alu_control = 3'b100;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            default: take = 1'b0;
        endcase
    end

    assign pc_write      = ~reset & (pc_update | (branch & take));
    assign ir_write      = ~reset & ir_write_c;
    assign mem_write     = ~reset & mem_write_c;
    assign reg_write     = ~reset & reg_write_c;
    assign illegal_instr = ~reset & illegal_c;
    assign instr_retire  = ~reset & retire_c;
    assign state         = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control FSM; checks at the falling clock edge.
module tb_multicycle_control_unit;
    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic       illegal_instr, instr_retire;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_control_unit #(.STATE_W(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .reg_write(reg_write),
        .illegal_instr(illegal_instr), .instr_retire(instr_retire), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        step();
        step();
        chk("rst_state", state, 8'd0);
        chk("rst_ir_write", ir_write, 8'd0);
        chk("rst_pc_write", pc_write, 8'd0);
        chk("rst_reg_write", reg_write, 8'd0);
        chk("rst_mem_write", mem_write, 8'd0);
        chk("rst_retire", instr_retire, 8'd0);
        chk("rst_alu_src_b", alu_src_b, 8'd2);
        reset = 1'b0;
        #1;
        chk("fetch_ir_write", ir_write, 8'd1);
        chk("fetch_pc_write", pc_write, 8'd1);
        chk("fetch_alu_src_b", alu_src_b, 8'd2);
        chk("fetch_result_src", result_src, 8'd2);
        chk("fetch_adr_src", adr_src, 8'd0);

        // lw: 0,1,2,3,4,0
        step(); chk("lw_s1", state, 8'd1);
        chk("dec_alu_src_a", alu_src_a, 8'd1);
        chk("dec_alu_src_b", alu_src_b, 8'd1);
        chk("dec_ir_write", ir_write, 8'd0);
        step(); chk("lw_s2", state, 8'd2);
        chk("memadr_a", alu_src_a, 8'd2);
        chk("memadr_ctl", alu_control, 8'd0);
        step(); chk("lw_s3", state, 8'd3);
        chk("memread_adr", adr_src, 8'd1);
        chk("memread_regw", reg_write, 8'd0);
        chk("memread_retire", instr_retire, 8'd0);
        step(); chk("lw_s4", state, 8'd4);
        chk("memwb_regw", reg_write, 8'd1);
        chk("memwb_res", result_src, 8'd1);
        chk("memwb_retire", instr_retire, 8'd1);
        step(); chk("lw_s0", state, 8'd0);
        chk("lw_end_retire", instr_retire, 8'd0);

        // sw: 0,1,2,5,0
        opcode = 7'b0100011; #1;
        chk("sw_imm", imm_src, 8'd1);
        step(); chk("sw_s1", state, 8'd1);
        step(); chk("sw_s2", state, 8'd2);
        chk("sw_memw_early", mem_write, 8'd0);
        step(); chk("sw_s5", state, 8'd5);
        chk("sw_memw", mem_write, 8'd1);
        chk("sw_adr", adr_src, 8'd1);
        chk("sw_retire", instr_retire, 8'd1);
        step(); chk("sw_s0", state, 8'd0);
        chk("sw_memw_after", mem_write, 8'd0);

        // R-type sub: 0,1,6,8,0
        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        step(); chk("sub_s1", state, 8'd1);
        step(); chk("sub_s6", state, 8'd6);
        chk("sub_ctl", alu_control, 8'd1);
        chk("sub_b", alu_src_b, 8'd0);
        funct3 = 3'b010; #1;
        chk("slt_ctl", alu_control, 8'd5);
        funct3 = 3'b111; #1;
        chk("and_ctl", alu_control, 8'd2);
        step(); chk("sub_s8", state, 8'd8);
        chk("aluwb_regw", reg_write, 8'd1);
        chk("aluwb_res", result_src, 8'd0);
        step(); chk("sub_s0", state, 8'd0);

        // addi with funct7b5=1 must still add: 0,1,7,8,0
        opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        step(); chk("addi_s1", state, 8'd1);
        step(); chk("addi_s7", state, 8'd7);
        chk("addi_ctl", alu_control, 8'd0);
        chk("addi_b", alu_src_b, 8'd1);
        funct3 = 3'b110; #1;
        chk("ori_ctl", alu_control, 8'd3);
        step(); chk("addi_s8", state, 8'd8);
        step(); chk("addi_s0", state, 8'd0);

        // beq
        opcode = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
        step(); chk("beq_s1", state, 8'd1);
        step(); chk("beq_s9", state, 8'd9);
        chk("beq_z1_pcw", pc_write, 8'd1);
        chk("beq_ctl", alu_control, 8'd1);
        chk("beq_imm", imm_src, 8'd2);
        chk("beq_retire", instr_retire, 8'd1);
        zero = 1'b0; #1;
        chk("beq_z0_pcw", pc_write, 8'd0);
        step(); chk("beq_s0", state, 8'd0);

        // bne
        funct3 = 3'b001; zero = 1'b1;
        step(); step(); chk("bne_s9", state, 8'd9);
        chk("bne_z1_pcw", pc_write, 8'd0);
        zero = 1'b0; #1;
        chk("bne_z0_pcw", pc_write, 8'd1);
        step();

        // funct3=100 never writes the PC
        funct3 = 3'b100; zero = 1'b1;
        step(); step(); chk("b100_s9", state, 8'd9);
        chk("b100_z1_pcw", pc_write, 8'd0);
        zero = 1'b0; #1;
        chk("b100_z0_pcw", pc_write, 8'd0);
        step(); chk("b100_s0", state, 8'd0);

        // jal: 0,1,10,8,0
        opcode = 7'b1101111; funct3 = 3'b000;
        step(); step(); chk("jal_s10", state, 8'd10);
        chk("jal_pcw", pc_write, 8'd1);
        chk("jal_a", alu_src_a, 8'd1);
        chk("jal_b", alu_src_b, 8'd2);
        chk("jal_imm", imm_src, 8'd3);
        chk("jal_retire", instr_retire, 8'd0);
        step(); chk("jal_s8", state, 8'd8);
        chk("jal_regw", reg_write, 8'd1);
        step(); chk("jal_s0", state, 8'd0);

        // illegal opcode
        opcode = 7'b1111111;
        step(); chk("ill_s1", state, 8'd1);
        chk("ill_pulse", illegal_instr, 8'd1);
        chk("ill_regw", reg_write, 8'd0);
        chk("ill_memw", mem_write, 8'd0);
        step(); chk("ill_s0", state, 8'd0);
        chk("ill_pulse_end", illegal_instr, 8'd0);
        chk("ill_imm", imm_src, 8'd0);

        // reset asserted during MEMWRITE
        opcode = 7'b0100011;
        step(); step(); step(); chk("rmw_s5", state, 8'd5);
        chk("rmw_memw_pre", mem_write, 8'd1);
        reset = 1'b1; #1;
        chk("rmw_memw_drop", mem_write, 8'd0);
        chk("rmw_state", state, 8'd0);
        chk("rmw_retire", instr_retire, 8'd0);
        step(); chk("rmw_hold_state", state, 8'd0);
        chk("rmw_hold_irw", ir_write, 8'd0);
        reset = 1'b0; #1;
        chk("rmw_rel_irw", ir_write, 8'd1);
        step(); chk("rmw_rel_s1", state, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
